// File: rtl/fir_pkg.sv
// fir_pkg: shared state encoding and arithmetic helpers for the time-multiplexed FIR
package fir_pkg;
  localparam int WIDE_W = 64;
  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
  function automatic int acc_width(input int data_w, input int coef_w, input int taps);
    return data_w + coef_w + $clog2(taps);
  endfunction
  // (2^sh)>>>1 is the half-LSB rounding term and collapses to zero when sh is zero
  function automatic logic signed [WIDE_W-1:0] rnd_shift(input logic signed [WIDE_W-1:0] v, input int sh);
    return (v + ((64'sd1 <<< sh) >>> 1)) >>> sh;
  endfunction
  function automatic logic signed [WIDE_W-1:0] sat(input logic signed [WIDE_W-1:0] v, input int w);
    logic signed [WIDE_W-1:0] hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    return v > hi ? hi : v < lo ? lo : v;
  endfunction
endpackage

// File: rtl/fir_mac.sv
// fir_mac: registered signed multiply-accumulate; acc_o already includes the current product
module fir_mac #(
  parameter int A_W   = 8,
  parameter int B_W   = 8,
  parameter int ACC_W = 19
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clr_i,
  input  logic                    en_i,
  input  logic signed [A_W-1:0]   a_i,
  input  logic signed [B_W-1:0]   b_i,
  output logic signed [ACC_W-1:0] acc_o
);
  logic signed [A_W+B_W-1:0] prod;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  assign prod  = a_i * b_i;
  assign acc_o = acc_q + ACC_W'(prod);
  always_comb acc_d = clr_i ? '0 : en_i ? acc_o : acc_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) acc_q <= '0;
    else acc_q <= acc_d;
endmodule

// File: rtl/fir_tdm.sv
// fir_tdm: time-multiplexed FIR, one tap per clock through a shared MAC,
// with a shadow coefficient bank copied into the active bank on each accepted sample
module fir_tdm
  import fir_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int TAPS   = 8,
  parameter int OUT_W  = 8,
  parameter int SHIFT  = 7
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic signed [DATA_W-1:0]  x,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic signed [OUT_W-1:0]   y,
  output logic                      out_valid,
  input  logic                      out_ready,
  input  logic                      coef_we,
  input  logic [$clog2(TAPS)-1:0]   coef_addr,
  input  logic signed [COEF_W-1:0]  coef_data
);
  localparam int ACC_W = acc_width(DATA_W, COEF_W, TAPS);
  localparam int AW    = $clog2(TAPS);
  state_t                    state_q, state_d;
  logic [AW-1:0]             k_q, k_d;
  logic signed [DATA_W-1:0]  d_q [TAPS];
  logic signed [COEF_W-1:0]  s_q [TAPS];
  logic signed [COEF_W-1:0]  c_q [TAPS];
  logic signed [OUT_W-1:0]   y_q, y_d;
  logic signed [ACC_W-1:0]   acc_nxt;
  logic signed [WIDE_W-1:0]  acc_ext;
  logic                      accept, mac_clr, mac_en, load_y;
  fir_mac #(.A_W(DATA_W), .B_W(COEF_W), .ACC_W(ACC_W)) u_mac (
    .clk   (clk),
    .reset (reset),
    .clr_i (mac_clr),
    .en_i  (mac_en),
    .a_i   (d_q[k_q]),
    .b_i   (c_q[k_q]),
    .acc_o (acc_nxt)
  );
  // y is captured on the last MAC edge so it is valid together with the OUT state
  assign acc_ext   = acc_nxt;
  assign y_d       = OUT_W'(sat(rnd_shift(acc_ext, SHIFT), OUT_W));
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == OUT;
  assign y         = y_q;
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    accept  = 1'b0;
    mac_clr = 1'b0;
    mac_en  = 1'b0;
    load_y  = 1'b0;
    case (state_q)
      IDLE: if (in_valid) begin
        accept  = 1'b1;
        mac_clr = 1'b1;
        k_d     = '0;
        state_d = MAC;
      end
      MAC: begin
        mac_en = 1'b1;
        k_d    = k_q + 1'b1;
        if (k_q == AW'(TAPS - 1)) begin
          load_y  = 1'b1;
          state_d = OUT;
        end
      end
      OUT: state_d = out_ready ? IDLE : OUT;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      d_q <= '{default: '0};
      s_q <= '{default: '0};
      c_q <= '{default: '0};
      y_q <= '0;
    end else begin
      if (coef_we && 32'(coef_addr) < TAPS) s_q[coef_addr] <= coef_data;
      if (accept) begin
        d_q[0] <= x;
        for (int i = 1; i < TAPS; i++) d_q[i] <= d_q[i-1];
        c_q <= s_q;
      end
      if (load_y) y_q <= y_d;
    end
endmodule

// File: tb/tb_fir_tdm.sv
// tb_fir_tdm: scoreboard bench driving SHIFT=0 and SHIFT=7 filters in lockstep
module tb_fir_tdm;
  localparam int TAPS = 8;
  typedef struct { int y0; int y7; int cyc; } exp_t;
  logic              clk = 0, reset = 1;
  logic signed [7:0] x = 0;
  logic              in_valid = 0, out_ready = 1, coef_we = 0;
  logic [2:0]        coef_addr = 0;
  logic signed [7:0] coef_data = 0;
  logic              in_ready0, in_ready7, out_valid0, out_valid7;
  logic signed [7:0] y0, y7;
  int                n_chk = 0, n_err = 0, cyc = 0;
  exp_t              q[$];
  exp_t              e;
  int                dl [TAPS];
  int                sh [TAPS];
  longint            acc;
  logic              prev_ov = 0;
  fir_tdm #(.SHIFT(0)) u0 (
    .clk(clk), .reset(reset), .x(x), .in_valid(in_valid), .in_ready(in_ready0),
    .y(y0), .out_valid(out_valid0), .out_ready(out_ready),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data)
  );
  fir_tdm #(.SHIFT(7)) u7 (
    .clk(clk), .reset(reset), .x(x), .in_valid(in_valid), .in_ready(in_ready7),
    .y(y7), .out_valid(out_valid7), .out_ready(out_ready),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask
  function automatic int rnd_sat(input longint a, input int s);
    longint r;
    r = a;
    if (s > 0) r = (a + (longint'(1) << (s - 1))) >>> s;
    return r > 127 ? 127 : r < -128 ? -128 : int'(r);
  endfunction
  always @(negedge clk) begin
    if (reset) begin
      q.delete();
      dl = '{default: 0};
      sh = '{default: 0};
      prev_ov = 0;
    end else begin
      if (out_valid0 && !prev_ov)
        check("latency", q.size() > 0 ? cyc - q[0].cyc : -1, TAPS + 1);
      if (out_valid0 && out_ready) begin
        check("sb_nonempty", q.size() > 0, 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          check("y_shift0", y0, e.y0);
          check("y_shift7", y7, e.y7);
          check("ov_shift7", out_valid7, 1);
        end
      end
      if (in_valid && in_ready0) begin
        for (int i = TAPS - 1; i > 0; i--) dl[i] = dl[i-1];
        dl[0] = x;
        acc = 0;
        for (int i = 0; i < TAPS; i++) acc += longint'(dl[i]) * sh[i];
        q.push_back('{rnd_sat(acc, 0), rnd_sat(acc, 7), cyc});
      end
      if (coef_we && coef_addr < TAPS) sh[coef_addr] = coef_data;
      prev_ov = out_valid0;
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic load_coefs(input int base, input int step);
    for (int i = 0; i < TAPS; i++) begin
      coef_we = 1;
      coef_addr = 3'(i);
      coef_data = 8'(base + step * i);
      tick();
    end
    coef_we = 0;
  endtask
  task automatic send(input int v);
    int n = 0;
    in_valid = 1;
    x = 8'(v);
    while (!in_ready0 && n < 100) begin
      tick();
      n++;
    end
    check("send_ready", in_ready0, 1);
    tick();
    in_valid = 0;
  endtask
  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 500) begin
      tick();
      n++;
    end
    check("drain", q.size(), 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    repeat (3) tick();
    check("rst_y", y0, 0);
    check("rst_ov", out_valid0, 0);
    reset = 0;
    tick();
    check("rst_in_ready", in_ready0, 1);
    // impulse through ramp coefficients
    load_coefs(1, 1);
    send(1);
    repeat (8) send(0);
    drain();
    // saturation in both directions
    load_coefs(127, 0);
    repeat (3) send(127);
    repeat (3) send(-128);
    drain();
    // rounding at SHIFT=7
    load_coefs(64, 0);
    send(1);
    repeat (7) send(0);
    send(-1);
    drain();
    // backpressure
    out_ready = 0;
    send(3);
    for (int i = 0; i < 50 && !out_valid0; i++) tick();
    check("bp_out_valid", out_valid0, 1);
    in_valid = 1;
    x = 9;
    for (int i = 0; i < 5; i++) begin
      check("bp_ov_hold", out_valid0, 1);
      check("bp_y_hold", y0, q.size() > 0 ? q[0].y0 : -999);
      check("bp_in_ready", in_ready0, 0);
      tick();
    end
    out_ready = 1;
    tick();
    check("bp_idle", in_ready0, 1);
    check("bp_ov_low", out_valid0, 0);
    tick();
    check("bp_accepted", in_ready0, 0);
    in_valid = 0;
    drain();
    // shadow coefficients: writes at acceptance and during MAC affect only later samples
    load_coefs(1, 1);
    repeat (TAPS) send(0);
    drain();
    check("sh_pre_ready", in_ready0, 1);
    in_valid = 1;
    x = 1;
    coef_we = 1;
    coef_addr = 0;
    coef_data = 9;
    tick();
    in_valid = 0;
    coef_data = 5;
    tick();
    coef_we = 0;
    drain();
    check("sh_cur_out", y0, 1);
    repeat (TAPS - 1) send(0);
    send(1);
    drain();
    check("sh_next_out", y0, 5);
    // reset in the middle of MAC
    send(1);
    repeat (3) tick();
    reset = 1;
    #1;
    check("mid_rst_y0", y0, 0);
    check("mid_rst_y7", y7, 0);
    check("mid_rst_ov", out_valid0, 0);
    tick();
    reset = 0;
    check("mid_rst_ready", in_ready0, 1);
    load_coefs(1, 1);
    send(1);
    drain();
    check("post_rst_y", y0, 1);
    repeat (3) send(0);
    drain();
    check("sb_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
